// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for DIGITS common-anode
// 7-segment digits that share one decoder. A frame-stable shadow copy of the
// value is shown one digit per slot, with a blanking gap at each slot start.
module display_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GAP    = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [3:0]            sel,
    output logic [DIGITS-1:0]     an,
    output logic                  upd
);

    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DIGIT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]      cnt_reg;
    logic [DIGIT_W-1:0]    digit_reg;
    logic [4*DIGITS-1:0]   staging_reg;
    logic [4*DIGITS-1:0]   shadow_reg;
    logic                  pending_reg;
    logic                  upd_reg;

    logic                  slot_end;
    logic                  frame_end;
    logic                  on_phase;
    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     nib_zero;
    logic [DIGITS-1:0]     lead_blank;

    assign slot_end  = (cnt_reg == CNT_W'(DIV - 1));
    assign frame_end = slot_end && (digit_reg == DIGIT_W'(DIGITS - 1));
    assign on_phase  = (cnt_reg >= CNT_W'(GAP));

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]      = shadow_reg[gi*4 +: 4];
            assign nib_zero[gi] = (shadow_reg[gi*4 +: 4] == 4'b0000);
            // Only the selected digit's anode is pulled low, and only in ON phase.
            assign an[gi]       = ~(on_phase && (digit_reg == DIGIT_W'(gi)));
        end
    endgenerate

    // Leading-zero mask: digit k is blanked when it and every digit above it are zero.
    always_comb begin
        logic run_zero;
        run_zero   = 1'b1;
        lead_blank = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_zero = run_zero & nib_zero[k];
            if (k != 0) begin
                lead_blank[k] = blank_lz & run_zero;
            end
        end
    end

    // Decoder select: blank during the gap or for a suppressed leading zero.
    always_comb begin
        sel = 4'b1111;
        if (on_phase && !lead_blank[digit_reg]) begin
            sel = nib[digit_reg];
        end
    end

    assign upd = upd_reg;

    // Slot counter and digit index; the digit advances when a slot finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            digit_reg <= '0;
        end else if (slot_end) begin
            cnt_reg <= '0;
            if (digit_reg == DIGIT_W'(DIGITS - 1)) begin
                digit_reg <= '0;
            end else begin
                digit_reg <= digit_reg + DIGIT_W'(1);
            end
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Value capture: loads land in staging and are promoted to the shadow only at
    // a frame boundary; a load on the boundary cycle itself bypasses staging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging_reg <= '0;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
            upd_reg     <= 1'b0;
        end else if (frame_end) begin
            if (load) begin
                shadow_reg  <= value;
                staging_reg <= value;
                pending_reg <= 1'b0;
                upd_reg     <= 1'b1;
            end else if (pending_reg) begin
                shadow_reg  <= staging_reg;
                pending_reg <= 1'b0;
                upd_reg     <= 1'b1;
            end else begin
                upd_reg     <= 1'b0;
            end
        end else begin
            upd_reg <= 1'b0;
            if (load) begin
                staging_reg <= value;
                pending_reg <= 1'b1;
            end
        end
    end

endmodule
